pipelined_data_memory: RTL and testbench
========================================

PIPELINED_DATA_MEMORY -- requirements
Module: pipelined_data_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width; memory depth = 2**ADDR_W bytes.
REQ-002 SHALL have parameter INIT_ZERO, default 1, which zero-initialises the whole array at time 0 when 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request; sampled only when ready=1.
REQ-006 SHALL have port rw  input  1  1=store, 0=load.
REQ-007 SHALL have port size  input  2  00=byte, 01=halfword, 10=word, 11=doubleword (two beats).
REQ-008 SHALL have port se  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-009 SHALL have port addr  input  ADDR_W  byte address of the access.
REQ-010 SHALL have port di  input  32  store data; doubleword beat 1 = high word, beat 2 = low word.
REQ-011 SHALL have port ready  output  1  block accepts a new req this cycle.
REQ-012 SHALL have port dout  output  32  registered load data.
REQ-013 SHALL have port dout_valid  output  1  dout holds a completed load beat.
REQ-014 SHALL have port misalign  output  1  one-cycle pulse: accepted access was misaligned.

Function
REQ-015 Byte order SHALL be big-endian: mem[A] holds the MSB of any multi-byte item.
REQ-016 Load data SHALL be registered: an accepted load at cycle N puts data on dout with dout_valid=1 at cycle N+1.
REQ-017 Byte load: {24{se&mem[A][7]}, mem[A]}. Halfword load: {16{se&mem[A][7]}, mem[A], mem[A+1]}. Word load: mem[A..A+3]; se ignored.
REQ-018 Stores SHALL write on the accepting edge; byte, halfword and word write 1, 2 and 4 bytes from di LSBs upward.
REQ-019 FSM SHALL have states IDLE and BEAT2; ready=1 only in IDLE.
REQ-020 IDLE -> BEAT2 on an accepted size=11 access. Address A+4 is latched, together with rw; beat 1 is a word access at A.
REQ-021 In BEAT2, the second word access SHALL run at the latched address with di sampled for stores; req is ignored; the FSM then returns to IDLE.
REQ-022 A doubleword load SHALL produce dout_valid on two consecutive cycles: high word, then low word.
REQ-023 Byte-offset arithmetic (A+1..A+7) SHALL wrap modulo 2**ADDR_W.
REQ-024 When no load completes, dout_valid SHALL be 0 and dout SHALL hold its last value.
REQ-025 Back-to-back accepted accesses in IDLE SHALL be legal every cycle.
REQ-026 A load that follows a store to the same address on the next cycle SHALL return the new data.
REQ-027 In a single cycle a store and a load never coexist: one access per cycle.

Reset
REQ-028 While rst_n=0: state=IDLE, ready=1, dout=0, dout_valid=0, misalign=0, latched address/rw=0.
REQ-029 If rst_n falls mid-doubleword, the BEAT2 access SHALL be abandoned, with no write and no valid.
REQ-030 Reset SHALL NOT clear the memory array.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-032 With the macro defined, alignment SHALL be checked: halfword requires addr[0]=0, word requires addr[1:0]=0, doubleword requires addr[2:0]=0.
REQ-033 With the macro defined, a misaligned accepted access SHALL pulse misalign=1 the next cycle, write nothing, and give dout_valid=0; a misaligned doubleword SHALL stay in IDLE.
REQ-034 Without the macro, misalign SHALL be tied 0 and every access SHALL proceed at any address.

Verification
REQ-035 Store word 0xDEADBEEF @0x010, then load byte se=1 @0x010 -> dout=0xFFFFFFDE valid at N+1; se=0 -> 0x000000DE.
REQ-036 Store halfword 0x8001 @0x020, then load halfword se=1 -> 0xFFFF8001; load word @0x020 -> 0x8001xxxx (upper bytes as written).
REQ-037 Doubleword store 0x11223344 / 0x55667788 @0x040 with ready=0 for 1 cycle -> doubleword load returns 0x11223344 then 0x55667788 on consecutive cycles.
REQ-038 Store word @0x1FE without DMEM_ALIGN_CHECK_EN -> bytes land at 0x1FE, 0x1FF, 0x000, 0x001 (wrap); with the macro -> misalign=1, memory unchanged.
REQ-039 Assert rst_n=0 during BEAT2 of a doubleword store -> low word not written, ready=1, dout_valid=0.

Source files
------------

// File: rtl/pipelined_data_memory.sv
// Big-endian byte-addressed data memory with registered loads and two-beat doubleword accesses.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses and suppress their effect.
module pipelined_data_memory #(
    parameter int ADDR_W    = 9,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              se,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       di,
    output logic              ready,
    output logic [31:0]       dout,
    output logic              dout_valid,
    output logic              misalign
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic { IDLE = 1'b0, BEAT2 = 1'b1 } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] beatAddr_q, beatAddr_d;
    logic              beatRw_q, beatRw_d;
    logic [31:0]       dout_q, dout_d;
    logic              doutValid_q, doutValid_d;
    logic              misalign_q, misalign_d;

    logic [7:0] mem [DEPTH] = '{default: (INIT_ZERO ? 8'h00 : 8'hxx)};

    logic              accEn, accRw, accSe, misReq, doAccess, wrEn;
    logic [1:0]        accSize;
    logic [ADDR_W-1:0] accAddr, accAddr1, accAddr2, accAddr3;
    logic [31:0]       loadData;

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        misReq = 1'b0;
        if (state_q == IDLE && req) begin
            case (size)
                2'b01:   misReq = addr[0];
                2'b10:   misReq = |addr[1:0];
                2'b11:   misReq = |addr[2:0];
                default: misReq = 1'b0;
            endcase
        end
    end
`else
    assign misReq = 1'b0;
`endif

    // A doubleword runs as two word accesses; the second uses the latched address and rw.
    always_comb begin
        state_d    = state_q;
        beatAddr_d = beatAddr_q;
        beatRw_d   = beatRw_q;
        accEn      = 1'b0;
        accRw      = rw;
        accSize    = size;
        accSe      = se;
        accAddr    = addr;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accEn = 1'b1;
                    if (size == 2'b11) begin
                        accSize = 2'b10;
                        if (!misReq) begin
                            state_d    = BEAT2;
                            beatAddr_d = addr + ADDR_W'(4);
                            beatRw_d   = rw;
                        end
                    end
                end
            end
            BEAT2: begin
                accEn   = 1'b1;
                accRw   = beatRw_q;
                accSize = 2'b10;
                accSe   = 1'b0;
                accAddr = beatAddr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign doAccess = accEn & ~misReq;
    assign wrEn     = doAccess & accRw & rst_n;
    assign accAddr1 = accAddr + ADDR_W'(1);
    assign accAddr2 = accAddr + ADDR_W'(2);
    assign accAddr3 = accAddr + ADDR_W'(3);

    always_comb begin
        loadData = {mem[accAddr], mem[accAddr1], mem[accAddr2], mem[accAddr3]};
        case (accSize)
            2'b00:   loadData = {{24{accSe & mem[accAddr][7]}}, mem[accAddr]};
            2'b01:   loadData = {{16{accSe & mem[accAddr][7]}}, mem[accAddr], mem[accAddr1]};
            default: loadData = {mem[accAddr], mem[accAddr1], mem[accAddr2], mem[accAddr3]};
        endcase
    end

    always_comb begin
        doutValid_d = doAccess & ~accRw;
        dout_d      = doutValid_d ? loadData : dout_q;
        misalign_d  = misReq;
    end

    // Stores take the low bytes of di, most significant of them at the lowest address.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            case (accSize)
                2'b00: mem[accAddr] <= di[7:0];
                2'b01: begin
                    mem[accAddr]  <= di[15:8];
                    mem[accAddr1] <= di[7:0];
                end
                default: begin
                    mem[accAddr]  <= di[31:24];
                    mem[accAddr1] <= di[23:16];
                    mem[accAddr2] <= di[15:8];
                    mem[accAddr3] <= di[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beatAddr_q  <= '0;
            beatRw_q    <= 1'b0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beatAddr_q  <= beatAddr_d;
            beatRw_q    <= beatRw_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            misalign_q  <= misalign_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Testbench for pipelined_data_memory: directed cases plus random traffic against a byte-array reference model.
module tb_pipelined_data_memory;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req, rw, se;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       di;
    logic              ready;
    logic [31:0]       dout;
    logic              dout_valid, misalign;

    pipelined_data_memory #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rw         (rw),
        .size       (size),
        .se         (se),
        .addr       (addr),
        .di         (di),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  refMem [DEPTH];
    bit          mBeat2;
    int unsigned mBeatAddr;
    bit          mBeatRw;
    logic [31:0] expDout;
    bit          expValid, expMis, expReady;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, "/ready"}, 32'(ready), 32'(expReady));
        checkOutput({phase, "/dout_valid"}, 32'(dout_valid), 32'(expValid));
        checkOutput({phase, "/misalign"}, 32'(misalign), 32'(expMis));
        checkOutput({phase, "/dout"}, dout, expDout);
    endtask

    // Big-endian item of sz (0=byte,1=half,2=word) at byte address a, wrapping modulo DEPTH.
    task automatic modelAccess(input bit w, input int sz, input bit sgn, input int unsigned a,
                               input logic [31:0] d);
        int     n;
        longint val;
        n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        if (w) begin
            for (int k = 0; k < n; k++)
                refMem[(a + k) % DEPTH] = 8'(d >> (8 * (n - 1 - k)));
        end else begin
            val = 0;
            for (int k = 0; k < n; k++)
                val = val * 256 + longint'(refMem[(a + k) % DEPTH]);
            if (sgn && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                val = val - (longint'(1) << (8 * n));
            expDout  = 32'(val);
            expValid = 1'b1;
        end
    endtask

    task automatic modelStep();
        int sz;
        bit bad;
        expValid = 1'b0;
        expMis   = 1'b0;
        sz       = int'(size);
        bad      = 1'b0;
        if (!mBeat2) begin
            if (req) begin
`ifdef DMEM_ALIGN_CHECK_EN
                bad = (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0) ||
                      (sz == 3 && addr % 8 != 0);
`endif
                if (bad) begin
                    expMis = 1'b1;
                end else begin
                    modelAccess(rw, (sz == 3) ? 2 : sz, se, int'(addr), di);
                    if (sz == 3) begin
                        mBeat2    = 1'b1;
                        mBeatAddr = (int'(addr) + 4) % DEPTH;
                        mBeatRw   = rw;
                    end
                end
            end
        end else begin
            modelAccess(mBeatRw, 2, 1'b0, mBeatAddr, di);
            mBeat2 = 1'b0;
        end
        expReady = !mBeat2;
    endtask

    task automatic modelReset();
        mBeat2   = 1'b0;
        expDout  = '0;
        expValid = 1'b0;
        expMis   = 1'b0;
        expReady = 1'b1;
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [1:0] s, input logic e,
                                 input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        req  = r;
        rw   = w;
        size = s;
        se   = e;
        addr = a;
        di   = d;
        modelStep();
        @(posedge clk);
        #1;
        checkAll("step");
    endtask

    initial begin
        int pick;
        logic [ADDR_W-1:0] ra;
        rst_n = 1'b0;
        req = 1'b0; rw = 1'b0; size = 2'b00; se = 1'b0; addr = '0; di = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 9'h010, 32'h0);
        checkOutput("lb_sext", dout, 32'hFFFFFFDE);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 9'h010, 32'h0);
        checkOutput("lb_zext", dout, 32'h000000DE);

        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 9'h020, 32'h00008001);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 9'h020, 32'h0);
        checkOutput("lh_sext", dout, 32'hFFFF8001);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0);
        checkOutput("lw_upper", {16'h0, dout[31:16]}, 32'h00008001);

        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 9'h040, 32'h11223344);
        checkOutput("dw_busy", 32'(ready), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 9'h1F3, 32'h55667788);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 9'h040, 32'h0);
        checkOutput("dw_hi", dout, 32'h11223344);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
        checkOutput("dw_lo", dout, 32'h55667788);
        checkOutput("dw_lo_valid", 32'(dout_valid), 32'h1);

        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 9'h1FE, 32'hA1B2C3D4);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
`ifndef DMEM_ALIGN_CHECK_EN
        checkOutput("wrap_b000", dout, 32'h000000C3);
`endif
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 9'h1FF, 32'h0);
`ifndef DMEM_ALIGN_CHECK_EN
        checkOutput("wrap_b1ff", dout, 32'h000000B2);
`endif

        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 9'h084, 32'h12345678);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 9'h080, 32'hAAAAAAAA);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        di    = 32'hBBBBBBBB;
        modelReset();
        #1;
        checkAll("rst_async");
        @(posedge clk);
        #1;
        checkAll("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 9'h084, 32'h0);
        checkOutput("rst_lo_kept", dout, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 9'h080, 32'h0);
        checkOutput("rst_hi_written", dout, 32'hAAAAAAAA);

        for (int i = 0; i < 600; i++) begin
            pick = int'($urandom_range(0, 2));
            if (pick == 0)      ra = ADDR_W'($urandom_range(0, 40));
            else if (pick == 1) ra = ADDR_W'($urandom_range(DEPTH - 8, DEPTH - 1));
            else                ra = ADDR_W'($urandom_range(0, DEPTH - 1));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
